// File: rtl/alu_multicycle.sv
// Clocked ALU with a valid/ready handshake. Single-cycle ops finish on the accept edge.
// MUL (shift-add) and DIVU (restoring) iterate one bit per cycle over WIDTH cycles.
module alu_multicycle #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [5:0]       alufn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] otp,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [5:0] OpAdd  = 6'b000000;
  localparam logic [5:0] OpSub  = 6'b000001;
  localparam logic [5:0] OpMul  = 6'b000010;
  localparam logic [5:0] OpDivu = 6'b000011;
  localparam logic [5:0] OpAnd  = 6'b000100;
  localparam logic [5:0] OpOr   = 6'b000101;
  localparam logic [5:0] OpXor  = 6'b000110;
  localparam logic [5:0] OpNor  = 6'b000111;
  localparam logic [5:0] OpSll  = 6'b001000;
  localparam logic [5:0] OpSrl  = 6'b001001;
  localparam logic [5:0] OpSra  = 6'b001010;

  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] otp_q, otp_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  // Single-cycle datapath, fed straight from the inputs on the accept edge.
  logic [WIDTH-1:0] sum, diff, sra_res, sc_res;
  logic [SHW-1:0]   shamt;
  logic             sc_ovf, sc_ill;

  assign sum     = a + b;
  assign diff    = a - b;
  assign shamt   = b[SHW-1:0];
  assign sra_res = $unsigned($signed(a) >>> shamt);

  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (alufn)
      OpAdd: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   sc_res = a & b;
      OpOr:    sc_res = a | b;
      OpXor:   sc_res = a ^ b;
      OpNor:   sc_res = ~(a | b);
      OpSll:   sc_res = a << shamt;
      OpSrl:   sc_res = a >> shamt;
      OpSra:   sc_res = sra_res;
      default: sc_ill = 1'b1;
    endcase
  end

  // Iterative datapath. acc holds the product high half (MUL) or the remainder (DIVU);
  // q holds the multiplier shifting out (MUL) or the dividend/quotient (DIVU).
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_sub;
  logic             div_ge;
  logic [WIDTH-1:0] iter_acc, iter_q;
  logic             is_mul;

  assign is_mul    = (op_q == OpMul);
  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_sub   = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    if (is_mul) begin
      iter_acc = mul_sum[WIDTH:1];
      iter_q   = {mul_sum[0], q_q[WIDTH-1:1]};
    end else begin
      iter_acc = div_ge ? div_sub : div_shift[WIDTH-1:0];
      iter_q   = {q_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    b_d     = b_q;
    q_d     = q_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    otp_d   = otp_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    ill_d   = ill_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = alufn;
          b_d  = b;
          if (alufn == OpMul || alufn == OpDivu) begin
            q_d     = a;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StBusy;
          end else begin
            otp_d   = sc_res;
            zero_d  = (sc_res == '0);
            ovf_d   = sc_ovf;
            ill_d   = sc_ill;
            state_d = StDone;
          end
        end
      end
      StBusy: begin
        acc_d = iter_acc;
        q_d   = iter_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          ill_d   = 1'b0;
          state_d = StDone;
          if (is_mul) begin
            otp_d = iter_q;
            ovf_d = (iter_acc != '0);
          end else if (b_q == '0) begin
            otp_d = '1;
            ovf_d = 1'b1;
          end else begin
            otp_d = iter_q;
            ovf_d = 1'b0;
          end
          zero_d = (otp_d == '0);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      b_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      otp_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      q_q     <= q_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      otp_q   <= otp_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign otp       = otp_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, clocked successor to the processor's combinational ALU.
- Keeps the 6-bit alufn encoding: group in alufn[5:2], op in alufn[1:0].
- Adds the missing ops: DIVU, NOR, SRA.
- MUL and DIVU are iterative multi-cycle engines; all ops use a valid/ready handshake so the pipeline can stall the execute stage on them.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alufn  in  6  operation code.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer accepts the result.
- otp  out  WIDTH  result.
- zero  out  1  1 when otp == 0.
- overflow  out  1  op-specific overflow / error flag.
- illegal  out  1  alufn not a defined code.

Behaviour:
- Reset: one synchronous reset, active-high, on clk. On a clk edge with reset=1: state=IDLE, out_valid=0, otp=0, zero=0, overflow=0, illegal=0, iteration counter=0. Reset aborts any in-flight MUL/DIVU; no result is produced.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating, in_ready=0.
  - DONE: out_valid=1, in_ready=0.
- Accept: a request is accepted on an edge with state=IDLE and in_valid=1. a, b and alufn are registered at that edge; later input changes are ignored.
- Single-cycle ops: IDLE → DONE on the accept edge. out_valid=1 in the next cycle (latency 1).
- MUL/DIVU: IDLE → BUSY on the accept edge. BUSY lasts exactly WIDTH cycles (one bit per cycle), then → DONE. out_valid rises WIDTH+1 cycles after accept.
- DONE → IDLE on an edge with out_ready=1. While out_ready=0, otp, zero, overflow and illegal hold stable.
- No accept in DONE: maximum throughput is one op per 2 cycles (single-cycle ops).
- Op codes (6'b gggg_oo):
  - 000000 ADD: otp=a+b mod 2^WIDTH. overflow=signed overflow (operand sign bits equal, result sign differs).
  - 000001 SUB: otp=a-b. overflow=signed overflow (operand signs differ, result sign ≠ a sign).
  - 000010 MUL: unsigned shift-add. otp=low WIDTH bits of product. overflow=1 iff the high WIDTH bits of the 2·WIDTH product are nonzero.
  - 000011 DIVU: unsigned restoring division, otp=a/b.
    - b==0: otp=all ones, overflow=1, still WIDTH BUSY cycles.
    - Otherwise overflow=0.
  - 000100 AND, 000101 OR, 000110 XOR, 000111 NOR: overflow=0.
  - 001000 SLL: otp=a<<b[SHW-1:0].
  - 001001 SRL: otp=a>>b[SHW-1:0], logical.
  - 001010 SRA: otp=a>>>b[SHW-1:0], arithmetic.
  - Shifts: upper bits of b are ignored; overflow=0.
  - Any other code: illegal=1, otp=0, overflow=0. Single-cycle path, still completes the handshake.
- zero: valid together with out_valid; zero=1 iff otp==0, including for illegal codes.
- in_valid during BUSY/DONE: ignored, not queued; the requester must hold it until in_ready.
- in_valid and out_ready together in DONE: only the DONE→IDLE move occurs; the new request is taken the following cycle.

Test Plan:
- Reset: reset high 2 cycles mid-MUL (a=7, b=9) → out_valid never rises, in_ready=1 after reset, all outputs 0.
- ADD overflow: ADD a=32'h7FFFFFFF, b=1 → 1 cycle later out_valid=1, otp=32'h80000000, overflow=1, zero=0.
- SUB to zero: SUB a=5, b=5 → otp=0, zero=1, overflow=0.
- MUL latency: MUL a=32'h0001_0000, b=32'h0001_0000 → out_valid exactly 33 cycles after accept, otp=0, zero=1, overflow=1.
- DIVU:
  - DIVU a=100, b=7 → otp=14 after 33 cycles.
  - DIVU a=3, b=0 → otp=32'hFFFFFFFF, overflow=1.
- Back-pressure, shifts and illegal:
  - SRA a=32'h80000000, b=32'h24 (shift 4) with out_ready low 5 cycles → otp=32'hF8000000 held stable.
  - in_valid pulses during the hold are ignored.
  - alufn=6'b111111 → illegal=1, otp=0, zero=1.
